// File: rtl/seg7_reader_if.sv
// Handshake bundle for seg7_reader: a segment-digit input stream and a decoded 32-bit word output stream.
interface seg7_reader_if;
    logic [6:0]  SEG_IN;
    logic        SEG_VALID;
    logic        SEG_READY;
    logic [31:0] WORD_OUT;
    logic        WORD_VALID;
    logic        WORD_READY;
    logic        ERR;
    logic [2:0]  ERR_POS;
    logic        BCD_OK;

    modport slave (
        input  SEG_IN, SEG_VALID, WORD_READY,
        output SEG_READY, WORD_OUT, WORD_VALID, ERR, ERR_POS, BCD_OK
    );

    modport master (
        output SEG_IN, SEG_VALID, WORD_READY,
        input  SEG_READY, WORD_OUT, WORD_VALID, ERR, ERR_POS, BCD_OK
    );
endinterface

// File: rtl/seg7_reader.sv
// Collects eight active-low 7-segment digits into a 32-bit nibble word and offers it with error/BCD flags.
// Optional macro SEG7_BLANK_EN: the all-off pattern decodes as a recognised 0 (leading blanks).
module seg7_reader (
    input  logic          CLOCK_50,
    input  logic          RST,
    seg7_reader_if.slave  bus
);

    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        err_q, err_d;
    logic [2:0]  err_pos_q, err_pos_d;
    logic        bcd_ok_q, bcd_ok_d;
    logic [4:0]  dec;
    logic        xfer;

    // Returns {unrecognised, nibble}; input is active-low so invert to segment-on notation first.
    function automatic logic [4:0] decode(input logic [6:0] seg_n);
        logic [6:0] on;
        logic [4:0] r;
        on = ~seg_n;
        case (on)
            7'h3F:   r = {1'b0, 4'h0};
            7'h06:   r = {1'b0, 4'h1};
            7'h5B:   r = {1'b0, 4'h2};
            7'h4F:   r = {1'b0, 4'h3};
            7'h66:   r = {1'b0, 4'h4};
            7'h6D:   r = {1'b0, 4'h5};
            7'h7D:   r = {1'b0, 4'h6};
            7'h07:   r = {1'b0, 4'h7};
            7'h7F:   r = {1'b0, 4'h8};
            7'h6F:   r = {1'b0, 4'h9};
            7'h77:   r = {1'b0, 4'hA};
            7'h7C:   r = {1'b0, 4'hB};
            7'h58:   r = {1'b0, 4'hC};
            7'h5E:   r = {1'b0, 4'hD};
            7'h79:   r = {1'b0, 4'hE};
            7'h71:   r = {1'b0, 4'hF};
`ifdef SEG7_BLANK_EN
            7'h00:   r = {1'b0, 4'h0};
`endif
            default: r = {1'b1, 4'h0};
        endcase
        return r;
    endfunction

    function automatic logic all_bcd(input logic [31:0] w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (w[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    assign xfer = bus.SEG_VALID && (state_q == COLLECT);

    always_ff @(posedge CLOCK_50) begin
        if (RST) state_q <= COLLECT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (xfer && cnt_q == 3'd7) state_d = HOLD;
            HOLD:    if (bus.WORD_READY)        state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_comb begin
        bus.SEG_READY  = (state_q == COLLECT);
        bus.WORD_VALID = (state_q == HOLD);
        bus.WORD_OUT   = word_q;
        bus.ERR        = err_q;
        bus.ERR_POS    = err_pos_q;
        bus.BCD_OK     = bcd_ok_q;
    end

    // Word is not cleared on hand-off: it is simply overwritten by the next eight shifts.
    always_comb begin
        cnt_d     = cnt_q;
        word_d    = word_q;
        err_d     = err_q;
        err_pos_d = err_pos_q;
        bcd_ok_d  = bcd_ok_q;
        dec       = decode(bus.SEG_IN);
        if (xfer) begin
            word_d = {word_q[27:0], dec[3:0]};
            cnt_d  = cnt_q + 3'd1;
            if (dec[4] && !err_q) begin
                err_d     = 1'b1;
                err_pos_d = cnt_q;
            end
            if (cnt_q == 3'd7) bcd_ok_d = all_bcd(word_d) && !err_d;
        end else if (state_q == HOLD && bus.WORD_READY) begin
            cnt_d     = 3'd0;
            err_d     = 1'b0;
            err_pos_d = 3'd0;
            bcd_ok_d  = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            cnt_q     <= 3'd0;
            word_q    <= 32'd0;
            err_q     <= 1'b0;
            err_pos_q <= 3'd0;
            bcd_ok_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            err_q     <= err_d;
            err_pos_q <= err_pos_d;
            bcd_ok_q  <= bcd_ok_d;
        end
    end

endmodule
